// File: rtl/mode_counter.sv
// Multi-mode up/down counter: one binary index, presented as binary or Gray code,
// with programmable modulus, enable, clamped parallel load and a registered wrap pulse.
module mode_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 2**WIDTH - 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       M,
    output logic [WIDTH-1:0] COUNT,
    output logic             TC
);

    localparam logic [WIDTH-1:0] MAX_IDX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        idx_d = idx_q;
        tc_d  = 1'b0;
        if (LOAD) begin
            // Out-of-range load values clamp to 0 so the index never leaves 0..MAX.
            idx_d = (D <= MAX_IDX) ? D : '0;
        end else if (ENABLE) begin
            if (!M[1]) begin
                if (idx_q == MAX_IDX) begin
                    idx_d = '0;
                    tc_d  = 1'b1;
                end else begin
                    idx_d = idx_q + ONE;
                end
            end else begin
                if (idx_q == '0) begin
                    idx_d = MAX_IDX;
                    tc_d  = 1'b1;
                end else begin
                    idx_d = idx_q - ONE;
                end
            end
        end
        // Encoding follows the mode on this edge, so a mode change re-encodes even when held.
        count_d = M[0] ? (idx_d ^ (idx_d >> 1)) : idx_d;
    end

    always_ff @(posedge CLOCK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (RESET) begin
            idx_q   <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign COUNT = count_q;
    assign TC    = tc_q;

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench: two counter configurations (3-bit/MAX=7 and 4-bit/MAX=9) share
// control stimulus; a table, hand sequences and random steps are checked against a model.
module tb_mode_counter;

    logic       clk = 1'b0;
    logic       rst, en, ld;
    logic [3:0] d;
    logic [1:0] m;
    logic [2:0] count_a;
    logic       tc_a;
    logic [3:0] count_b;
    logic       tc_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (plain integers, modulus arithmetic)
    int  idx_a, idx_b, exp_cnt_a, exp_cnt_b;
    bit  exp_tc_a, exp_tc_b;
    bit  model_valid = 1'b0;

    mode_counter #(.WIDTH(3), .MAX(7)) dut_a (
        .CLOCK(clk), .RESET(rst), .ENABLE(en), .LOAD(ld),
        .D(d[2:0]), .M(m), .COUNT(count_a), .TC(tc_a)
    );

    mode_counter #(.WIDTH(4), .MAX(9)) dut_b (
        .CLOCK(clk), .RESET(rst), .ENABLE(en), .LOAD(ld),
        .D(d), .M(m), .COUNT(count_b), .TC(tc_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       r, e, l;
        bit [3:0] dv;
        bit [1:0] mv;
        int       cnt;
        bit       tc;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_step(input int maxv, input bit r, e, l, input int dv,
                                     input int mv, inout int idx, output int cnt,
                                     output bit tc);
        tc = 1'b0;
        if (r) begin
            idx = 0;
            cnt = 0;
            return;
        end
        if (l) begin
            idx = (dv <= maxv) ? dv : 0;
        end else if (e) begin
            if (mv >= 2) begin
                tc  = (idx == 0);
                idx = (idx + maxv) % (maxv + 1);
            end else begin
                tc  = (idx == maxv);
                idx = (idx + 1) % (maxv + 1);
            end
        end
        cnt = (mv % 2 == 1) ? (idx ^ (idx >> 1)) : idx;
    endfunction

    // Apply one edge of stimulus, advance the model, and compare both instances.
    task automatic step(input bit r, e, l, input bit [3:0] dv, input bit [1:0] mv);
        rst = r; en = e; ld = l; d = dv; m = mv;
        @(posedge clk);
        #1;
        ref_step(7, r, e, l, int'(dv) % 8, int'(mv), idx_a, exp_cnt_a, exp_tc_a);
        ref_step(9, r, e, l, int'(dv), int'(mv), idx_b, exp_cnt_b, exp_tc_b);
        if (r) model_valid = 1'b1;
        if (model_valid) begin
            check("model_a_count", int'(count_a), exp_cnt_a);
            check("model_a_tc", int'(tc_a), int'(exp_tc_a));
            check("model_b_count", int'(count_b), exp_cnt_b);
            check("model_b_tc", int'(tc_b), int'(exp_tc_b));
        end
    endtask

    function automatic void add(input bit r, e, l, input bit [3:0] dv, input bit [1:0] mv,
                                input int cnt, input bit tc);
        vec_t v;
        v.r = r; v.e = e; v.l = l; v.dv = dv; v.mv = mv; v.cnt = cnt; v.tc = tc;
        tbl.push_back(v);
    endfunction

    initial begin
        rst = 1'b0; en = 1'b0; ld = 1'b0; d = '0; m = '0;

        // Vectors for the 3-bit, MAX=7 instance: {rst,en,ld,d,m, COUNT, TC}
        add(1, 1, 1, 4'd5, 2'b00, 0, 0);               // reset beats load and enable
        add(1, 1, 1, 4'd5, 2'b00, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 1, 0, 4'd0, 2'b00, i, 0);
        add(0, 1, 0, 4'd0, 2'b00, 0, 1);               // binary wrap 7 -> 0
        add(0, 1, 0, 4'd0, 2'b00, 1, 0);
        add(1, 0, 0, 4'd0, 2'b01, 0, 0);
        add(0, 1, 0, 4'd0, 2'b01, 3'b001, 0);          // Gray up
        add(0, 1, 0, 4'd0, 2'b01, 3'b011, 0);
        add(0, 1, 0, 4'd0, 2'b01, 3'b010, 0);
        add(0, 1, 0, 4'd0, 2'b01, 3'b110, 0);
        add(0, 1, 0, 4'd0, 2'b01, 3'b111, 0);
        add(0, 1, 0, 4'd0, 2'b01, 3'b101, 0);
        add(0, 1, 0, 4'd0, 2'b01, 3'b100, 0);
        add(0, 1, 0, 4'd0, 2'b01, 3'b000, 1);
        add(0, 1, 0, 4'd0, 2'b11, 3'b100, 1);          // Gray down wraps from 0
        add(0, 1, 0, 4'd0, 2'b11, 3'b101, 0);
        add(0, 1, 0, 4'd0, 2'b11, 3'b111, 0);
        add(1, 0, 0, 4'd0, 2'b00, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 0, 4'd0, 2'b00, i, 0);
        add(0, 0, 0, 4'd0, 2'b11, 3'b111, 0);          // re-encode gray(5) while held
        add(0, 1, 0, 4'd0, 2'b11, 3'b110, 0);          // down from 5 -> gray(4)
        add(0, 0, 0, 4'd0, 2'b00, 4, 0);               // hold, binary view

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].dv, tbl[i].mv);
            check($sformatf("tbl%0d_count", i), int'(count_a), tbl[i].cnt);
            check($sformatf("tbl%0d_tc", i), int'(tc_a), int'(tbl[i].tc));
        end

        // Load and clamp on the 4-bit, MAX=9 instance
        step(0, 0, 1, 4'd6, 2'b00);
        check("load6_count", int'(count_b), 6);
        step(0, 0, 1, 4'd12, 2'b00);
        check("load12_clamp", int'(count_b), 0);
        step(0, 1, 1, 4'd9, 2'b00);
        check("load9_en_count", int'(count_b), 9);
        check("load9_en_tc", int'(tc_b), 0);
        step(0, 1, 0, 4'd0, 2'b00);
        check("wrap9_count", int'(count_b), 0);
        check("wrap9_tc", int'(tc_b), 1);

        // Reset mid-count in binary down mode, then resume from MAX
        step(0, 0, 1, 4'd3, 2'b10);
        check("load3_count", int'(count_b), 3);
        step(1, 1, 0, 4'd0, 2'b10);
        check("rst_mid_count", int'(count_b), 0);
        check("rst_mid_tc", int'(tc_b), 0);
        step(0, 1, 0, 4'd0, 2'b10);
        check("down_wrap_count", int'(count_b), 9);
        check("down_wrap_tc", int'(tc_b), 1);
        check("down_wrap_a_count", int'(count_a), 7);

        // Random control streams against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
